// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the LFSR pattern generator: programs seed/stop and streams LFSR words into a valid/ready FIFO.
// Latency: first word valid 8 cycles after start; backpressure halts the LFSR and reseeds it from the last word.
module lfsr_seq_ctrl #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic [DATA_W-1:0] stop_i,
  input  logic [CNT_W-1:0]  max_words_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              stop_hit_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic              lfsr_config_o,
  output logic              lfsr_config_rdy_o,
  output logic [DATA_W-1:0] lfsr_config_data_o,
  input  logic              lfsr_config_done_i,
  output logic              lfsr_en_o,
  input  logic [DATA_W-1:0] lfsr_data_i,
  input  logic              lfsr_rdy_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int FPW = $clog2(FIFO_DEPTH);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_SEED, S_WAIT_SEED, S_WR_STOP, S_WAIT_STOP, S_PRELOAD, S_RUN,
    S_HALT, S_RESEED, S_WAIT_RESEED, S_HOLD, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] seed_q, stop_q, last_q;
  logic [CNT_W-1:0]  max_q, word_cnt_q, cnt_inc;
  logic              stop_hit_q, en_q, halt_cnt_q;
  logic              push, pop, stop_match, limit_hit;

  logic [DATA_W-1:0] ent_q [FIFO_DEPTH];
  logic [FCW-1:0]    fifo_cnt_q, cnt_after, wr_idx;

  assign out_valid_o = (fifo_cnt_q != '0);
  assign out_data_o  = ent_q[0];
  assign pop         = out_valid_o && out_ready_i;
  assign wr_idx      = fifo_cnt_q - FCW'(pop);
  assign cnt_after   = fifo_cnt_q + FCW'(1) - FCW'(pop);

  assign push       = lfsr_rdy_i && (state_q == S_RUN || state_q == S_HALT);
  assign cnt_inc    = (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1);
  assign stop_match = push && (lfsr_data_i == stop_q);
  assign limit_hit  = push && (max_q != '0) && (cnt_inc == max_q);

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o     = (state_q == S_DONE);
  assign stop_hit_o = stop_hit_q;
  assign word_cnt_o = word_cnt_q;
  assign lfsr_en_o  = en_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:        if (start_i) state_d = (seed_i == stop_i) ? S_DONE : S_WR_SEED;
      S_WR_SEED:     state_d = S_WAIT_SEED;
      S_WAIT_SEED:   if (lfsr_config_done_i) state_d = S_WR_STOP;
      S_WR_STOP:     state_d = S_WAIT_STOP;
      S_WAIT_STOP:   if (lfsr_config_done_i) state_d = S_PRELOAD;
      S_PRELOAD:     state_d = S_RUN;
      S_RUN: begin
        if (stop_match || limit_hit)
          state_d = S_DRAIN;
        else if (push && cnt_after >= FCW'(FIFO_DEPTH - 2))
          state_d = S_HALT;
      end
      // One word can still be in flight after enable drops; two cycles covers it.
      S_HALT: begin
        if (stop_match || limit_hit)
          state_d = S_DRAIN;
        else if (halt_cnt_q)
          state_d = S_RESEED;
      end
      S_RESEED:      state_d = S_WAIT_RESEED;
      S_WAIT_RESEED: if (lfsr_config_done_i) state_d = S_HOLD;
      S_HOLD:        if (fifo_cnt_q < FCW'(FIFO_DEPTH - 2)) state_d = S_PRELOAD;
      S_DRAIN:       if (fifo_cnt_q == '0) state_d = S_DONE;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_config_rdy_o  = 1'b0;
    lfsr_config_o      = 1'b0;
    lfsr_config_data_o = '0;
    case (state_q)
      S_WR_SEED: begin
        lfsr_config_rdy_o  = 1'b1;
        lfsr_config_data_o = seed_q;
      end
      S_WR_STOP: begin
        lfsr_config_rdy_o  = 1'b1;
        lfsr_config_o      = 1'b1;
        lfsr_config_data_o = stop_q;
      end
      S_RESEED: begin
        lfsr_config_rdy_o  = 1'b1;
        lfsr_config_data_o = last_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      halt_cnt_q <= 1'b0;
      seed_q     <= '0;
      stop_q     <= '0;
      max_q      <= '0;
      last_q     <= '0;
      word_cnt_q <= '0;
      stop_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= (state_d == S_RUN);
      halt_cnt_q <= (state_q == S_HALT) ? ~halt_cnt_q : 1'b0;
      if (state_q == S_IDLE && start_i) begin
        seed_q     <= seed_i;
        stop_q     <= stop_i;
        max_q      <= max_words_i;
        word_cnt_q <= '0;
        stop_hit_q <= (seed_i == stop_i);
      end
      if (push) begin
        last_q     <= lfsr_data_i;
        word_cnt_q <= cnt_inc;
        if (stop_match) stop_hit_q <= 1'b1;
      end
    end
  end

  // Shift-register FIFO so the head is always a flop.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      if (pop)
        for (int i = 0; i < FIFO_DEPTH - 1; i++) ent_q[i] <= ent_q[i+1];
      if (push) ent_q[wr_idx[FPW-1:0]] <= lfsr_data_i;
      fifo_cnt_q <= fifo_cnt_q + FCW'(push) - FCW'(pop);
    end
  end

  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push && !pop && fifo_cnt_q == FCW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl with a behavioural XNOR LFSR attached to the config/data ports.
module tb_lfsr_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, cfg, cfg_rdy, cfg_done, busy, done, stop_hit;
  logic        lfsr_en, lfsr_rdy, out_valid, out_ready;
  logic [15:0] seed, stop, maxw, word_cnt, cfg_data, lfsr_data, out_data;

  always #5 clk = ~clk;

  lfsr_seq_ctrl #(.DATA_W(16), .FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .seed_i(seed), .stop_i(stop),
    .max_words_i(maxw), .busy_o(busy), .done_o(done), .stop_hit_o(stop_hit),
    .word_cnt_o(word_cnt), .lfsr_config_o(cfg), .lfsr_config_rdy_o(cfg_rdy),
    .lfsr_config_data_o(cfg_data), .lfsr_config_done_i(cfg_done), .lfsr_en_o(lfsr_en),
    .lfsr_data_i(lfsr_data), .lfsr_rdy_i(lfsr_rdy), .out_data_o(out_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return {x[14:0], ~(x[12] ^ x[3])};
  endfunction

  // Generator model: enable low reloads the seed, stops advancing once it sits on the stop value.
  logic [15:0] m_seed, m_stop, m_state;
  always @(posedge clk) begin
    if (reset) begin
      m_seed <= '0; m_stop <= '0; m_state <= '0; lfsr_rdy <= 1'b0; cfg_done <= 1'b0;
    end else begin
      cfg_done <= cfg_rdy;
      if (cfg_rdy) begin
        if (cfg) m_stop <= cfg_data;
        else     m_seed <= cfg_data;
      end
      if (!lfsr_en) begin
        m_state <= m_seed; lfsr_rdy <= 1'b0;
      end else if (m_state != m_stop) begin
        m_state <= nxt(m_state); lfsr_rdy <= 1'b1;
      end else begin
        lfsr_rdy <= 1'b0;
      end
    end
  end
  assign lfsr_data = m_state;

  int          n_asserts = 0, n_fail = 0;
  logic [15:0] words[$], exp_q[$], seed_dat[$], seed_last[$];
  logic [16:0] cfg_log[$];
  int          t_en, t_rdy, t_vld, t_done, stab_err;
  bit          got_done, en_seen, vld_seen, busy_at_done, post_done;
  logic        hit_at_done, hit_post;
  logic [15:0] cnt_at_done, cnt_post, last_prod;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outvec();
    return {9'd0, busy, done, stop_hit, word_cnt, cfg, cfg_rdy, cfg_data, lfsr_en, out_data, out_valid};
  endfunction

  function automatic void build_exp(input logic [15:0] s, input logic [15:0] p, input logic [15:0] m);
    logic [15:0] x;
    exp_q.delete();
    x = s;
    for (int i = 0; i < 4096; i++) begin
      x = nxt(x);
      exp_q.push_back(x);
      if (x == p) break;
      if (m != 0 && exp_q.size() == int'(m)) break;
    end
  endfunction

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_len"}, 64'(words.size()), 64'(exp_q.size()));
    n = (words.size() < exp_q.size()) ? words.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_word%0d", tag, i), 64'(words[i]), 64'(exp_q[i]));
  endtask

  task automatic do_run(input logic [15:0] s, input logic [15:0] p, input logic [15:0] m,
                        input int drop_at, input int low_len, input int inject_at, input int abort_at);
    int          low;
    bit          dropped, prev_hold;
    logic [15:0] prev_dat;
    words.delete(); cfg_log.delete(); seed_dat.delete(); seed_last.delete();
    t_en = -1; t_rdy = -1; t_vld = -1; t_done = -1; stab_err = 0;
    got_done = 0; en_seen = 0; vld_seen = 0; busy_at_done = 1; post_done = 0;
    low = 0; dropped = 0; prev_hold = 0; prev_dat = '0; last_prod = '0;
    out_ready = 1'b1;
    seed = s; stop = p; maxw = m; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      if (c == abort_at) break;
      start = (c == inject_at);
      if (c == inject_at) begin seed = 16'h00FF; stop = 16'h0003; maxw = 16'd2; end
      if (drop_at > 0 && !dropped && words.size() >= drop_at) begin
        dropped = 1; low = low_len; out_ready = 1'b0;
      end else if (low > 0) begin
        low--;
        if (low == 0) out_ready = 1'b1;
      end
      if (prev_hold && out_data !== prev_dat) stab_err++;
      prev_hold = out_valid && !out_ready;
      prev_dat  = out_data;
      if (lfsr_en) begin en_seen = 1; if (t_en < 0) t_en = c; end
      if (lfsr_rdy && t_rdy < 0) t_rdy = c;
      if (out_valid) begin vld_seen = 1; if (t_vld < 0) t_vld = c; end
      if (out_valid && out_ready) words.push_back(out_data);
      if (cfg_rdy) begin
        cfg_log.push_back({cfg, cfg_data});
        if (!cfg) begin seed_dat.push_back(cfg_data); seed_last.push_back(last_prod); end
      end
      if (lfsr_rdy) last_prod = lfsr_data;
      if (done) begin
        got_done = 1; t_done = c; busy_at_done = busy;
        hit_at_done = stop_hit; cnt_at_done = word_cnt;
        break;
      end
      tick();
    end
    start = 1'b0;
    if (got_done) begin
      for (int k = 0; k < 5; k++) begin
        tick();
        if (done) post_done = 1;
        if (out_valid && out_ready) words.push_back(out_data);
      end
      hit_post = stop_hit;
      cnt_post = word_cnt;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seed = '0; stop = '0; maxw = '0; out_ready = 1'b1;
    tick(); tick();
    check("reset_outputs", outvec(), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_outputs", outvec(), 64'd0);

    // Stop match ends the run; stop word included.
    do_run(16'h0000, 16'h000F, 16'd0, 0, 0, 0, 0);
    exp_q = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
    check("t1_done", 64'(got_done), 64'd1);
    check_stream("t1");
    check("t1_stop_hit", 64'(hit_at_done), 64'd1);
    check("t1_word_cnt", 64'(cnt_at_done), 64'd4);
    check("t1_busy_at_done", 64'(busy_at_done), 64'd0);
    check("t1_done_pulse", 64'(post_done), 64'd0);
    check("t1_cfg_writes", 64'(cfg_log.size()), 64'd2);
    if (cfg_log.size() >= 2) begin
      check("t1_cfg_seed", 64'(cfg_log[0]), 64'h0_0000);
      check("t1_cfg_stop", 64'(cfg_log[1]), 64'h1_000F);
    end
    check("t1_first_en", 64'(t_en), 64'd6);
    check("t1_first_rdy", 64'(t_rdy), 64'd7);
    check("t1_first_vld", 64'(t_vld), 64'd8);
    check("t1_hit_held", 64'(hit_post), 64'd1);
    check("t1_cnt_held", 64'(cnt_post), 64'd4);

    // Word limit of 8, no stop match.
    do_run(16'h0000, 16'hFFFF, 16'd8, 0, 0, 0, 0);
    build_exp(16'h0000, 16'hFFFF, 16'd8);
    check("t2_done", 64'(got_done), 64'd1);
    check_stream("t2");
    check("t2_stop_hit", 64'(hit_at_done), 64'd0);
    check("t2_word_cnt", 64'(cnt_at_done), 64'd8);

    // Backpressure for 20 cycles after word 3 forces halt/reseed.
    do_run(16'h0000, 16'hFFFF, 16'd64, 3, 20, 0, 0);
    build_exp(16'h0000, 16'hFFFF, 16'd64);
    check("t3_done", 64'(got_done), 64'd1);
    check_stream("t3");
    check("t3_stop_hit", 64'(hit_at_done), 64'd0);
    check("t3_word_cnt", 64'(cnt_at_done), 64'd64);
    check("t3_reseed_seen", 64'(seed_dat.size() >= 2), 64'd1);
    for (int i = 1; i < seed_dat.size(); i++)
      check($sformatf("t3_reseed%0d_data", i), 64'(seed_dat[i]), 64'(seed_last[i]));
    check("t3_head_stable", 64'(stab_err), 64'd0);

    // Seed equals stop: immediate done, no LFSR activity.
    do_run(16'h1234, 16'h1234, 16'd0, 0, 0, 0, 0);
    check("t4_done", 64'(got_done), 64'd1);
    check("t4_done_latency", 64'(t_done >= 1 && t_done <= 2), 64'd1);
    check("t4_stop_hit", 64'(hit_at_done), 64'd1);
    check("t4_word_cnt", 64'(cnt_at_done), 64'd0);
    check("t4_en_seen", 64'(en_seen), 64'd0);
    check("t4_vld_seen", 64'(vld_seen), 64'd0);
    check("t4_cfg_writes", 64'(cfg_log.size()), 64'd0);

    // Reset in the middle of a run, then a fresh run.
    do_run(16'h0000, 16'hFFFF, 16'd0, 0, 0, 0, 12);
    check("t5_busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("t5_reset_outputs", outvec(), 64'd0);
    reset = 1'b0;
    tick();
    do_run(16'h0000, 16'h000F, 16'd0, 0, 0, 0, 0);
    build_exp(16'h0000, 16'h000F, 16'd0);
    check("t5_done", 64'(got_done), 64'd1);
    check_stream("t5");
    check("t5_word_cnt", 64'(cnt_at_done), 64'd4);
    check("t5_stop_hit", 64'(hit_at_done), 64'd1);

    // start_i during RUN must be ignored.
    do_run(16'h0000, 16'hFFFF, 16'd12, 0, 0, 10, 0);
    build_exp(16'h0000, 16'hFFFF, 16'd12);
    check("t6_done", 64'(got_done), 64'd1);
    check_stream("t6");
    check("t6_word_cnt", 64'(cnt_at_done), 64'd12);
    check("t6_stop_hit", 64'(hit_at_done), 64'd0);
    check("t6_cfg_writes", 64'(cfg_log.size()), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
